param_universal_shift_reg: RTL and testbench
============================================

# param_universal_shift_reg

Parametrised universal shift register and parallel-to-serial engine for the robot's peripheral datapath. It adds configurable width, rotate and arithmetic modes, and a self-timed burst mode to the basic hold/shift/load functions. Burst mode loads a word and shifts it out LSB-first over `WIDTH` enabled cycles, reporting progress on `busy` and `done`. It sits between the controller's parallel registers and serial peripheral lines.

## Interface
- `WIDTH`, default 8: register width in bits, minimum 2.
- `CNT_W`, default `$clog2(WIDTH+1)`: burst counter width; derived, not overridden.

- `clk` input, 1 bit: single clock, rising edge.
- `rst` input, 1 bit: asynchronous, active-low reset.
- `en` input, 1 bit: clock enable. When low, all state freezes, including an active burst.
- `mode` input, 3 bits: operation select; encoding under Operation.
- `din` input, `WIDTH` bits: parallel load data.
- `sir` input, 1 bit: serial in, shifted into the MSB on right shifts.
- `sil` input, 1 bit: serial in, shifted into the LSB on left shifts.
- `q` output, `WIDTH` bits: register contents.
- `so_r` output, 1 bit: `q[0]`, the bit leaving on a right shift.
- `so_l` output, 1 bit: `q[WIDTH-1]`, the bit leaving on a left shift.
- `busy` output, 1 bit: burst in progress.
- `done` output, 1 bit: one-cycle pulse after the final burst shift.
- `cnt` output, `CNT_W` bits: burst shifts remaining.

## Operation
- Mode encodings, applied when `en`=1 and `busy`=0:
  - 000 HOLD: `q` unchanged.
  - 001 SHR: `q` <= {`sir`, `q[W-1:1]`}.
  - 010 SHL: `q` <= {`q[W-2:0]`, `sil`}.
  - 011 LOAD: `q` <= `din`.
  - 100 ROR: `q` <= {`q[0]`, `q[W-1:1]`}.
  - 101 ROL: `q` <= {`q[W-2:0]`, `q[W-1]`}.
  - 110 ASR: `q` <= {`q[W-1]`, `q[W-1:1]`}.
  - 111 BURST: `q` <= `din`, `cnt` <= `WIDTH`, `busy` <= 1.
- State machine has two states:
  - IDLE: `busy`=0. Modes execute as listed above.
  - SHIFTING: `busy`=1. `mode` and `din` are ignored. Each `en`=1 edge performs SHR with `sir` and decrements `cnt`.
  - SHIFTING leaves when `cnt` goes from 1 to 0. On that edge: final shift, `busy` <= 0, `done` <= 1. The next state is IDLE.
- `done` is registered. It is high for exactly one cycle after the final-shift edge and is otherwise 0.
- `done` is not stalled by `en`. It clears on the next edge regardless of `en`.
- Back-to-back bursts: a BURST presented during the `done` cycle is accepted (the state is IDLE).
- `cnt` is 0 in IDLE. There is no wrap: `cnt` never decrements below 0.
- Reset is asynchronous and applies mid-burst. It forces `q`=0, `cnt`=0, `busy`=0, `done`=0, and the state to IDLE. `so_r` and `so_l` therefore read 0.

## Timing
- Every register updates on the rising `clk` edge. `so_r` and `so_l` are combinational from `q`, with no extra latency.
- Every mode has 1-cycle latency: the result is visible in `q` the cycle after the edge.
- Burst serialisation, with edge E0 as the accepting edge:
  - Before shift k (k = 0..W-1), `so_r` = `din[k]`. The receiver samples `so_r` on each edge where `busy`=1 and `en`=1.
  - With `en` held high, the final shift is at E`WIDTH`, so `busy` is high for exactly `WIDTH` cycles.
  - `done` is high in the cycle following E`WIDTH`.
- Each `en`=0 cycle during a burst extends `busy` by one cycle. Data and `cnt` are held during the stall.

## Structure
- Shared package `usr_pkg` holds:
  - the `usr_mode_e` enum for the 3-bit encodings above;
  - the `usr_state_e` enum {IDLE, SHIFTING}.
- One flat module, with no sub-module. The shift/rotate next-value mux and the burst FSM/counter share the `q` register.

## Test plan
- Reset, then LOAD `din`=8'hA5 → `q`=8'hA5, `so_r`=1, `so_l`=1. Assert `rst`=0 asynchronously → `q`=8'h00 immediately.
- Start from `q`=8'h81.
  - ROR → 8'hC0; ROL from 8'h81 → 8'h03.
  - ASR → 8'hC0; SHR with `sir`=0 from 8'h81 → 8'h40.
  - SHL with `sil`=1 from 8'h81 → 8'h03.
- BURST `din`=8'h96 with `en`=1 throughout:
  - `so_r` sequence 0,1,1,0,1,0,0,1;
  - `busy` high for exactly 8 cycles, `cnt` 8→0;
  - `done` high for 1 cycle, then 0.
- BURST with `en` low for 3 cycles mid-burst, and `mode` toggled to LOAD during the burst:
  - `q` and `cnt` frozen during the stall;
  - LOAD ignored;
  - `busy` lasts 11 cycles and the `so_r` sequence is unchanged.
- BURST reissued during the `done` cycle → the second burst starts with no gap. `rst` pulsed at shift 4 → all outputs 0 and state IDLE; `done` never pulses.
- `WIDTH`=2 and `WIDTH`=16 builds: the BURST of 16'hF00F emits 1,1,1,1, then eight 0s, then 1,1,1,1, and `cnt` resets to 16.

Source files
------------

// File: rtl/param_universal_shift_reg_pkg.sv
// Shared types for the universal shift register: operation encodings and
// burst state machine states.
package usr_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD  = 3'b000,
        MODE_SHR   = 3'b001,
        MODE_SHL   = 3'b010,
        MODE_LOAD  = 3'b011,
        MODE_ROR   = 3'b100,
        MODE_ROL   = 3'b101,
        MODE_ASR   = 3'b110,
        MODE_BURST = 3'b111
    } usr_mode_e;

    typedef enum logic {
        IDLE,
        SHIFTING
    } usr_state_e;

endpackage

// File: rtl/param_universal_shift_reg_if.sv
// Control/data bundle between the controller (master) and the shift
// register (slave).
interface param_universal_shift_reg_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
);
    logic             en;
    logic [2:0]       mode;
    logic [WIDTH-1:0] din;
    logic             sir;
    logic             sil;
    logic [WIDTH-1:0] q;
    logic             so_r;
    logic             so_l;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] cnt;

    modport master (
        output en, mode, din, sir, sil,
        input  q, so_r, so_l, busy, done, cnt
    );

    modport slave (
        input  en, mode, din, sir, sil,
        output q, so_r, so_l, busy, done, cnt
    );
endinterface

// File: rtl/param_universal_shift_reg.sv
// Universal shift register with rotate/arithmetic modes and a self-timed
// burst mode that serialises a loaded word LSB-first on so_r.
module param_universal_shift_reg
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input logic clk,
    input logic rst,
    param_universal_shift_reg_if.slave bus
);

    usr_state_e       state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            q_q     <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // done defaults low every edge, so it is a single-cycle pulse even when en is low.
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.en) begin
                    case (usr_mode_e'(bus.mode))
                        MODE_HOLD:  q_d = q_q;
                        MODE_SHR:   q_d = {bus.sir, q_q[WIDTH-1:1]};
                        MODE_SHL:   q_d = {q_q[WIDTH-2:0], bus.sil};
                        MODE_LOAD:  q_d = bus.din;
                        MODE_ROR:   q_d = {q_q[0], q_q[WIDTH-1:1]};
                        MODE_ROL:   q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                        MODE_ASR:   q_d = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
                        MODE_BURST: begin
                            q_d     = bus.din;
                            cnt_d   = CNT_W'(WIDTH);
                            state_d = SHIFTING;
                        end
                        default:    q_d = q_q;
                    endcase
                end
            end
            SHIFTING: begin
                if (bus.en) begin
                    q_d = {bus.sir, q_q[WIDTH-1:1]};
                    // Treat a zero count as finished too, so the counter can never wrap.
                    if (cnt_q <= CNT_W'(1)) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.q    = q_q;
    assign bus.so_r = q_q[0];
    assign bus.so_l = q_q[WIDTH-1];
    assign bus.busy = (state_q == SHIFTING);
    assign bus.done = done_q;
    assign bus.cnt  = cnt_q;

endmodule

// File: tb/tb_param_universal_shift_reg.sv
// Directed bench for the universal shift register: mode vector table, burst
// serialisation with stalls, back-to-back bursts, mid-burst reset, 2/16-bit builds.
module tb_param_universal_shift_reg;
    import usr_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    param_universal_shift_reg_if #(.WIDTH(8))  bus8();
    param_universal_shift_reg_if #(.WIDTH(16)) bus16();
    param_universal_shift_reg_if #(.WIDTH(2))  bus2();

    param_universal_shift_reg #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));
    param_universal_shift_reg #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
    param_universal_shift_reg #(.WIDTH(2))  dut2  (.clk(clk), .rst(rst), .bus(bus2));

    typedef struct {
        logic [7:0] pre;
        logic [2:0] mode;
        logic [7:0] din;
        logic       sir;
        logic       sil;
        logic       en;
        logic [7:0] expQ;
    } vec_t;

    vec_t vecs[13];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic [2:0] mode,
                                 input logic [7:0] din, input logic sir, input logic sil);
        bus8.en   = en;
        bus8.mode = mode;
        bus8.din  = din;
        bus8.sir  = sir;
        bus8.sil  = sil;
    endtask

    // Starts an 8-bit burst and walks it to the done cycle; optional stall of
    // stallLen cycles before shift stallAt, with LOAD presented during the burst.
    task automatic runBurst(input logic [7:0] word, input int stallAt, input int stallLen,
                            input string tag);
        int         busyCycles;
        logic [7:0] qHold;
        logic [3:0] cntHold;
        busyCycles = 0;
        applyStimulus(1'b1, MODE_BURST, word, 1'b0, 1'b0);
        tick();
        if (stallLen > 0) applyStimulus(1'b1, MODE_LOAD, ~word, 1'b0, 1'b0);
        else              applyStimulus(1'b1, MODE_HOLD, ~word, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            checkOutput($sformatf("%s so_r[%0d]", tag, k), 32'(bus8.so_r), 32'(word[k]));
            checkOutput($sformatf("%s cnt[%0d]", tag, k), 32'(bus8.cnt), 32'(8 - k));
            checkOutput($sformatf("%s busy[%0d]", tag, k), 32'(bus8.busy), 32'd1);
            busyCycles += int'(bus8.busy);
            if (k == stallAt) begin
                qHold   = bus8.q;
                cntHold = bus8.cnt;
                bus8.en = 1'b0;
                for (int s = 0; s < stallLen; s++) begin
                    tick();
                    busyCycles += int'(bus8.busy);
                end
                checkOutput($sformatf("%s stall q", tag), 32'(bus8.q), 32'(qHold));
                checkOutput($sformatf("%s stall cnt", tag), 32'(bus8.cnt), 32'(cntHold));
                checkOutput($sformatf("%s stall done", tag), 32'(bus8.done), 32'd0);
                bus8.en = 1'b1;
            end
            tick();
        end
        checkOutput($sformatf("%s end busy", tag), 32'(bus8.busy), 32'd0);
        checkOutput($sformatf("%s end done", tag), 32'(bus8.done), 32'd1);
        checkOutput($sformatf("%s end cnt", tag), 32'(bus8.cnt), 32'd0);
        checkOutput($sformatf("%s end q", tag), 32'(bus8.q), 32'd0);
        checkOutput($sformatf("%s busy cycles", tag), 32'(busyCycles), 32'(8 + stallLen));
    endtask

    initial begin
        logic        sawDone;
        logic [15:0] word16;
        logic [7:0]  word8;
        logic [1:0]  word2;

        checks   = 0;
        failures = 0;

        vecs[0]  = '{8'h81, MODE_ROR,  8'h00, 1'b0, 1'b0, 1'b1, 8'hC0};
        vecs[1]  = '{8'h81, MODE_ROL,  8'h00, 1'b0, 1'b0, 1'b1, 8'h03};
        vecs[2]  = '{8'h81, MODE_ASR,  8'h00, 1'b0, 1'b0, 1'b1, 8'hC0};
        vecs[3]  = '{8'h81, MODE_SHR,  8'h00, 1'b0, 1'b0, 1'b1, 8'h40};
        vecs[4]  = '{8'h81, MODE_SHR,  8'h00, 1'b1, 1'b0, 1'b1, 8'hC0};
        vecs[5]  = '{8'h81, MODE_SHL,  8'h00, 1'b0, 1'b1, 1'b1, 8'h03};
        vecs[6]  = '{8'h81, MODE_SHL,  8'h00, 1'b0, 1'b0, 1'b1, 8'h02};
        vecs[7]  = '{8'h81, MODE_HOLD, 8'hFF, 1'b1, 1'b1, 1'b1, 8'h81};
        vecs[8]  = '{8'h81, MODE_LOAD, 8'h3C, 1'b0, 1'b0, 1'b1, 8'h3C};
        vecs[9]  = '{8'h81, MODE_ROR,  8'h00, 1'b0, 1'b0, 1'b0, 8'h81};
        vecs[10] = '{8'h42, MODE_ASR,  8'h00, 1'b1, 1'b0, 1'b1, 8'h21};
        vecs[11] = '{8'h5A, MODE_ROL,  8'h00, 1'b0, 1'b0, 1'b1, 8'hB4};
        vecs[12] = '{8'h5A, MODE_ROR,  8'h00, 1'b0, 1'b0, 1'b1, 8'h2D};

        applyStimulus(1'b0, MODE_HOLD, 8'h00, 1'b0, 1'b0);
        bus16.en = 1'b0; bus16.mode = MODE_HOLD; bus16.din = '0; bus16.sir = 1'b0; bus16.sil = 1'b0;
        bus2.en  = 1'b0; bus2.mode  = MODE_HOLD; bus2.din  = '0; bus2.sir  = 1'b0; bus2.sil  = 1'b0;

        rst = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        checkOutput("reset q", 32'(bus8.q), 32'd0);
        checkOutput("reset busy", 32'(bus8.busy), 32'd0);
        checkOutput("reset cnt", 32'(bus8.cnt), 32'd0);
        checkOutput("reset done", 32'(bus8.done), 32'd0);
        rst = 1'b1;

        applyStimulus(1'b1, MODE_LOAD, 8'hA5, 1'b0, 1'b0);
        tick();
        checkOutput("load q", 32'(bus8.q), 32'hA5);
        checkOutput("load so_r", 32'(bus8.so_r), 32'd1);
        checkOutput("load so_l", 32'(bus8.so_l), 32'd1);
        #2 rst = 1'b0;
        #1;
        checkOutput("async rst q", 32'(bus8.q), 32'd0);
        checkOutput("async rst so_r", 32'(bus8.so_r), 32'd0);
        checkOutput("async rst so_l", 32'(bus8.so_l), 32'd0);
        rst = 1'b1;

        for (int i = 0; i < 13; i++) begin
            applyStimulus(1'b1, MODE_LOAD, vecs[i].pre, 1'b0, 1'b0);
            tick();
            applyStimulus(vecs[i].en, vecs[i].mode, vecs[i].din, vecs[i].sir, vecs[i].sil);
            tick();
            checkOutput($sformatf("vec%0d q", i), 32'(bus8.q), 32'(vecs[i].expQ));
            checkOutput($sformatf("vec%0d so_r", i), 32'(bus8.so_r), 32'(vecs[i].expQ[0]));
            checkOutput($sformatf("vec%0d so_l", i), 32'(bus8.so_l), 32'(vecs[i].expQ[7]));
            checkOutput($sformatf("vec%0d busy", i), 32'(bus8.busy), 32'd0);
        end

        runBurst(8'h96, -1, 0, "burst");
        applyStimulus(1'b0, MODE_HOLD, 8'h00, 1'b0, 1'b0);
        tick();
        checkOutput("burst done clears with en low", 32'(bus8.done), 32'd0);
        checkOutput("burst idle busy", 32'(bus8.busy), 32'd0);

        runBurst(8'h96, 3, 3, "stall");
        word8 = 8'h3C;
        applyStimulus(1'b1, MODE_BURST, word8, 1'b0, 1'b0);
        tick();
        checkOutput("b2b busy", 32'(bus8.busy), 32'd1);
        checkOutput("b2b cnt", 32'(bus8.cnt), 32'd8);
        checkOutput("b2b done", 32'(bus8.done), 32'd0);
        checkOutput("b2b q", 32'(bus8.q), 32'h3C);
        applyStimulus(1'b1, MODE_HOLD, 8'h00, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("b2b so_r[%0d]", k), 32'(bus8.so_r), 32'(word8[k]));
            tick();
        end
        #2 rst = 1'b0;
        #1;
        checkOutput("mid rst q", 32'(bus8.q), 32'd0);
        checkOutput("mid rst busy", 32'(bus8.busy), 32'd0);
        checkOutput("mid rst cnt", 32'(bus8.cnt), 32'd0);
        checkOutput("mid rst done", 32'(bus8.done), 32'd0);
        checkOutput("mid rst so_r", 32'(bus8.so_r), 32'd0);
        checkOutput("mid rst so_l", 32'(bus8.so_l), 32'd0);
        rst = 1'b1;
        sawDone = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            sawDone = sawDone | bus8.done;
        end
        checkOutput("post rst no done", 32'(sawDone), 32'd0);
        checkOutput("post rst idle", 32'(bus8.busy), 32'd0);
        applyStimulus(1'b0, MODE_HOLD, 8'h00, 1'b0, 1'b0);

        word16 = 16'hF00F;
        bus16.en = 1'b1; bus16.mode = MODE_BURST; bus16.din = word16;
        tick();
        bus16.mode = MODE_HOLD; bus16.din = 16'h0000;
        for (int k = 0; k < 16; k++) begin
            checkOutput($sformatf("w16 so_r[%0d]", k), 32'(bus16.so_r), 32'(word16[k]));
            checkOutput($sformatf("w16 cnt[%0d]", k), 32'(bus16.cnt), 32'(16 - k));
            tick();
        end
        checkOutput("w16 busy end", 32'(bus16.busy), 32'd0);
        checkOutput("w16 done", 32'(bus16.done), 32'd1);
        bus16.en = 1'b0;

        bus2.en = 1'b1; bus2.mode = MODE_LOAD; bus2.din = 2'b01;
        tick();
        bus2.mode = MODE_ROL;
        tick();
        checkOutput("w2 rol", 32'(bus2.q), 32'h2);
        bus2.mode = MODE_SHL; bus2.sil = 1'b1;
        tick();
        checkOutput("w2 shl", 32'(bus2.q), 32'h1);
        word2 = 2'b10;
        bus2.mode = MODE_BURST; bus2.din = word2; bus2.sil = 1'b0;
        tick();
        bus2.mode = MODE_HOLD;
        checkOutput("w2 cnt0", 32'(bus2.cnt), 32'd2);
        checkOutput("w2 so_r0", 32'(bus2.so_r), 32'(word2[0]));
        tick();
        checkOutput("w2 cnt1", 32'(bus2.cnt), 32'd1);
        checkOutput("w2 so_r1", 32'(bus2.so_r), 32'(word2[1]));
        tick();
        checkOutput("w2 busy end", 32'(bus2.busy), 32'd0);
        checkOutput("w2 done", 32'(bus2.done), 32'd1);
        bus2.en = 1'b0;
        tick();
        checkOutput("w2 done clear", 32'(bus2.done), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
